// File: rtl/led_frame_scheduler.sv
// led_frame_scheduler
//   Sequences one led_driver strand. Holds a double-buffered frame store
//   (front bank is shown, back bank is written by the host), answers the
//   driver's per-LED colour requests from the front bank, paces frames at
//   FRAME_CYCLES and issues the force_reset latch pulse between frames.
//   A committed back bank is swapped in only on entry to the latch pulse,
//   so a frame is never shown half-updated.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   enable_in               run frames; low = finish current frame, park IDLE
//   wr_en/wr_addr/wr_*      host write of {g,r,b} into the back bank
//   commit_in               back bank complete; swap at next frame boundary
//   commit_pending          commit waiting for a frame boundary
//   next_led_request,
//   request_valid           driver colour request
//   green/red/blue_out,
//   color_valid             colour answer (registered, held until next request)
//   force_reset             latch pulse to the driver
//   frame_start             1-cycle pulse when a frame begins streaming
//   frame_overrun           sticky: a frame overran FRAME_CYCLES
module led_frame_scheduler #(
    parameter int NUM_LEDS     = 2,
    parameter int FRAME_CYCLES = 1666666,
    parameter int RESET_CYCLES = 8000,
    parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          enable_in,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_green,
    input  logic [7:0]    wr_red,
    input  logic [7:0]    wr_blue,
    input  logic          commit_in,
    output logic          commit_pending,
    input  logic [AW-1:0] next_led_request,
    input  logic          request_valid,
    output logic [7:0]    green_out,
    output logic [7:0]    red_out,
    output logic [7:0]    blue_out,
    output logic          color_valid,
    output logic          force_reset,
    output logic          frame_start,
    output logic          frame_overrun
);

    localparam int TW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST   = TW'(FRAME_CYCLES - 1);
    localparam logic [RW-1:0] R_LAST   = RW'(RESET_CYCLES - 1);
    localparam logic [AW-1:0] LED_LAST = AW'(NUM_LEDS - 1);
    localparam logic [AW:0]   LED_NUM  = (AW+1)'(NUM_LEDS);

    typedef enum logic [1:0] {IDLE, RESET, STREAM, HOLD} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          front_q, front_d;
    logic          pending_q, pending_d;
    logic          reached_q, reached_d;   // timer hit T_LAST during this STREAM
    logic          overrun_q, overrun_d;
    logic          fstart_q, fstart_d;
    logic          cvalid_q, cvalid_d;
    logic [23:0]   color_q, color_d;
    logic [1:0][NUM_LEDS-1:0][23:0] bank_q;

    logic [23:0]   rd_word;
    logic          last_served;
    logic          enter_reset;

    // Front-bank lookup; out-of-range indices read as black.
    always_comb begin
        rd_word = '0;
        if ({1'b0, next_led_request} < LED_NUM)
            rd_word = bank_q[front_q][next_led_request];
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        rcnt_d      = rcnt_q;
        front_d     = front_q;
        pending_d   = pending_q | commit_in;
        reached_d   = reached_q;
        overrun_d   = overrun_q;
        fstart_d    = 1'b0;
        color_d     = color_q;
        cvalid_d    = cvalid_q;
        last_served = request_valid && (next_led_request == LED_LAST);

        if (request_valid) begin
            color_d  = rd_word;
            cvalid_d = 1'b1;
        end

        if (state_q != IDLE)
            timer_d = (timer_q == T_LAST) ? '0 : timer_q + TW'(1);

        case (state_q)
            IDLE:   if (enable_in) state_d = RESET;
            RESET: begin
                rcnt_d = rcnt_q + RW'(1);
                if (rcnt_q == R_LAST) begin
                    state_d   = STREAM;
                    fstart_d  = 1'b1;
                    timer_d   = '0;
                    reached_d = 1'b0;
                end
            end
            STREAM: begin
                if (timer_q == T_LAST) reached_d = 1'b1;
                if (last_served) begin
                    // reached_q means the timer already wrapped: the frame
                    // is late, so flag it and relatch without holding.
                    if (reached_q) overrun_d = 1'b1;
                    if (!enable_in)
                        state_d = IDLE;
                    else if (reached_q || (timer_q == T_LAST))
                        state_d = RESET;
                    else
                        state_d = HOLD;
                end
            end
            HOLD:   if (timer_q == T_LAST) state_d = RESET;
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) timer_d = '0;

        // Latch-pulse entry is the only frame boundary: swap here. A commit
        // arriving on this very edge is folded into the swap.
        enter_reset = (state_d == RESET) && (state_q != RESET);
        if (enter_reset) begin
            rcnt_d    = '0;
            front_d   = front_q ^ (pending_q | commit_in);
            pending_d = 1'b0;
            cvalid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            rcnt_q    <= '0;
            front_q   <= 1'b0;
            pending_q <= 1'b0;
            reached_q <= 1'b0;
            overrun_q <= 1'b0;
            fstart_q  <= 1'b0;
            cvalid_q  <= 1'b0;
            color_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            rcnt_q    <= rcnt_d;
            front_q   <= front_d;
            pending_q <= pending_d;
            reached_q <= reached_d;
            overrun_q <= overrun_d;
            fstart_q  <= fstart_d;
            cvalid_q  <= cvalid_d;
            color_q   <= color_d;
        end
    end

    // Writes always target the pre-swap back bank, even on the swap edge.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            bank_q <= '0;
        else if (wr_en && ({1'b0, wr_addr} < LED_NUM))
            bank_q[~front_q][wr_addr] <= {wr_green, wr_red, wr_blue};
    end

    assign commit_pending = pending_q;
    assign green_out      = color_q[23:16];
    assign red_out        = color_q[15:8];
    assign blue_out       = color_q[7:0];
    assign color_valid    = cvalid_q;
    assign force_reset    = (state_q == RESET);
    assign frame_start    = fstart_q;
    assign frame_overrun  = overrun_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
module tb_led_frame_scheduler;
    localparam int N  = 3;
    localparam int FC = 100;
    localparam int RC = 20;
    localparam int AW = 2;

    logic          clk_in = 1'b0;
    logic          rst_in, enable_in, wr_en, commit_in, request_valid;
    logic [AW-1:0] wr_addr, next_led_request;
    logic [7:0]    wr_green, wr_red, wr_blue;
    logic          commit_pending, color_valid, force_reset, frame_start, frame_overrun;
    logic [7:0]    green_out, red_out, blue_out;

    led_frame_scheduler #(.NUM_LEDS(N), .FRAME_CYCLES(FC), .RESET_CYCLES(RC)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_green(wr_green), .wr_red(wr_red), .wr_blue(wr_blue),
        .commit_in(commit_in), .commit_pending(commit_pending),
        .next_led_request(next_led_request), .request_valid(request_valid),
        .green_out(green_out), .red_out(red_out), .blue_out(blue_out),
        .color_valid(color_valid), .force_reset(force_reset),
        .frame_start(frame_start), .frame_overrun(frame_overrun)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Reference model: two banks, which one is shown, and a pending commit.
    logic [23:0] m_bank [2][N];
    int          m_front;
    bit          m_pending;
    logic [23:0] exp_q [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [23:0] m_look(int idx);
        return (idx < N) ? m_bank[m_front][idx] : 24'h0;
    endfunction

    task automatic m_clear();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) m_bank[b][i] = 24'h0;
        m_front = 0;
        m_pending = 0;
    endtask

    // Monitor: each served request is answered on the following cycle.
    bit          seen_req = 1'b0;
    logic [23:0] mon_e;
    always @(posedge clk_in) seen_req <= request_valid;
    always @(negedge clk_in) begin
        if (seen_req) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL scoreboard: answer with no expected entry");
            end else begin
                mon_e = exp_q.pop_front();
                check("colour", {green_out, red_out, blue_out}, mon_e);
                // a colour served on the latch-entry edge is not valid
                check("color_valid", color_valid, !force_reset);
            end
        end
    end

    task automatic wr(int a, logic [7:0] g, logic [7:0] r, logic [7:0] b);
        @(negedge clk_in);
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_green = g; wr_red = r; wr_blue = b;
        if (a < N) m_bank[1-m_front][a] = {g, r, b};
        @(posedge clk_in); #1 wr_en = 1'b0;
    endtask

    task automatic commit();
        @(negedge clk_in);
        commit_in = 1'b1; m_pending = 1;
        @(posedge clk_in); #1 commit_in = 1'b0;
    endtask

    task automatic req(int idx, output int edge_c);
        @(negedge clk_in);
        request_valid = 1'b1; next_led_request = idx[AW-1:0];
        exp_q.push_back(m_look(idx));
        edge_c = cyc + 1;
        @(posedge clk_in); #1 request_valid = 1'b0;
    endtask

    // Waits through a latch pulse to the next frame_start; the model swaps
    // banks when the pulse begins.
    task automatic wait_frame(output int rise_c, output int fs_c);
        int hi = 0;
        bit rose = 0;
        bit got = 0;
        rise_c = -1; fs_c = -1;
        for (int i = 0; i < 3*FC + RC; i++) begin
            @(negedge clk_in);
            if (force_reset) begin
                if (!rose) begin
                    rose = 1; rise_c = cyc;
                    if (m_pending) begin m_front = 1 - m_front; m_pending = 0; end
                end
                hi++;
            end
            if (frame_start) begin got = 1; fs_c = cyc; break; end
        end
        check("frame_start seen", got, 1);
        check("latch pulse length", hi, RC);
        check("commit_pending after boundary", commit_pending, m_pending);
    endtask

    initial begin
        #(400000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int fs_at, fs_new, rise, re, dummy, hits;
        rst_in = 1; enable_in = 0; wr_en = 0; commit_in = 0; request_valid = 0;
        wr_addr = '0; next_led_request = '0; wr_green = 0; wr_red = 0; wr_blue = 0;
        m_clear();
        repeat (3) @(posedge clk_in);
        #1 rst_in = 0;
        @(negedge clk_in);
        check("reset colour", {green_out, red_out, blue_out}, 24'h0);
        check("reset color_valid", color_valid, 0);
        check("reset force_reset", force_reset, 0);
        check("reset frame_start", frame_start, 0);
        check("reset frame_overrun", frame_overrun, 0);
        check("reset commit_pending", commit_pending, 0);

        // Frame A: first content, committed before enable.
        wr(0, 8'h3F, 8'h1F, 8'h00);
        wr(1, 8'h00, 8'h00, 8'h1F);
        wr(2, 8'h12, 8'h34, 8'h56);
        commit();
        @(negedge clk_in);
        check("commit_pending set", commit_pending, 1);
        enable_in = 1;
        wait_frame(rise, fs_at);
        req(0, dummy);
        req(1, dummy);
        wr(0, 8'hAA, 8'hBB, 8'hCC);   // back bank only, not committed
        req(0, dummy);
        @(negedge clk_in);
        check("no commit, no pending", commit_pending, 0);
        commit();
        @(negedge clk_in);
        check("mid-frame commit pending", commit_pending, 1);
        req(0, dummy);
        do @(negedge clk_in); while (cyc < fs_at + 30);
        req(N-1, dummy);
        wait_frame(rise, fs_new);
        check("frame period", rise - fs_at, FC);
        check("no overrun", frame_overrun, 0);
        fs_at = fs_new;

        // Frame B: new content, then a late last LED.
        req(0, dummy);
        req(1, dummy);
        do @(negedge clk_in); while (cyc < fs_at + 150);
        req(N-1, re);
        wait_frame(rise, fs_new);
        check("overrun relatch immediate", rise, re);
        check("overrun flagged", frame_overrun, 1);
        fs_at = fs_new;

        // Randomised frames.
        for (int f = 0; f < 4; f++) begin
            int nops;
            nops = $urandom_range(4, 10);
            for (int k = 0; k < nops; k++) begin
                case ($urandom_range(0, 3))
                    0, 1: req($urandom_range(0, N-2), dummy);
                    2: wr($urandom_range(0, N), 8'($urandom), 8'($urandom), 8'($urandom));
                    default: commit();
                endcase
            end
            req(N-1, dummy);
            repeat ($urandom_range(1, 4)) req($urandom_range(0, N), dummy);
            wait_frame(rise, fs_new);
            check("random frame period", rise - fs_at, FC);
            check("overrun sticky", frame_overrun, 1);
            fs_at = fs_new;
        end

        // Commit landing on the swap edge is consumed by the swap.
        wr(1, 8'h77, 8'h88, 8'h99);
        req(N-1, dummy);
        do @(negedge clk_in); while (cyc < fs_at + 99);
        check("commit aligned to boundary", cyc, fs_at + 99);
        commit_in = 1; m_pending = 1;
        @(posedge clk_in); #1 commit_in = 0;
        wait_frame(rise, fs_new);
        fs_at = fs_new;
        req(1, dummy);
        req(0, dummy);

        // Disable mid-stream: frame finishes, then park.
        @(negedge clk_in);
        enable_in = 0;
        req(N-1, dummy);
        hits = 0;
        repeat (150) begin
            @(negedge clk_in);
            if (force_reset || frame_start) hits++;
        end
        check("parked in idle", hits, 0);

        // Re-enable, then reset in the middle of the latch pulse.
        enable_in = 1;
        for (int i = 0; i < 10 && !force_reset; i++) @(negedge clk_in);
        check("relatch after idle", force_reset, 1);
        repeat (5) @(negedge clk_in);
        rst_in = 1; enable_in = 0;
        @(posedge clk_in); #1 rst_in = 0;
        m_clear();
        @(negedge clk_in);
        check("rst force_reset", force_reset, 0);
        check("rst colour", {green_out, red_out, blue_out}, 24'h0);
        check("rst color_valid", color_valid, 0);
        check("rst frame_overrun", frame_overrun, 0);
        check("rst commit_pending", commit_pending, 0);
        req(0, dummy);
        req(1, dummy);
        req(3, dummy);
        repeat (3) @(negedge clk_in);
        check("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
- Sequences one led_driver strand: serves its per-LED colour requests from a double-buffered frame store, paces frames at a fixed refresh period, and issues the driver's force_reset latch pulse between frames.
- Host logic writes the back bank and commits it; the bank swap happens only at a frame boundary, so a frame is never shown half-updated.
- Sits between host/pattern logic and led_driver in top_level.

Parameters:
- NUM_LEDS, 2, number of LEDs on the strand (>=1).
- FRAME_CYCLES, 1666666, clk_in cycles from one frame start to the next (60 Hz at 100 MHz).
- RESET_CYCLES, 8000, force_reset pulse length in cycles (80 us at 100 MHz; must be >=1).
- AW, $clog2(NUM_LEDS) (min 1), LED index width.

Ports:
- clk_in  input  1  system clock, single domain.
- rst_in  input  1  synchronous, active-high reset.
- enable_in  input  1  1 = run frames; 0 = finish the current frame and then park in IDLE.
- wr_en  input  1  write strobe into the back bank.
- wr_addr  input  AW  LED index to write.
- wr_green  input  8  green byte for the write.
- wr_red  input  8  red byte for the write.
- wr_blue  input  8  blue byte for the write.
- commit_in  input  1  pulse: the back bank is complete; swap it in at the next frame boundary.
- commit_pending  output  1  a commit is waiting for a frame boundary.
- next_led_request  input  AW  LED index requested by the driver.
- request_valid  input  1  one-cycle strobe qualifying next_led_request.
- green_out  output  8  colour to the driver's green_in.
- red_out  output  8  colour to the driver's red_in.
- blue_out  output  8  colour to the driver's blue_in.
- color_valid  output  1  to the driver's color_valid.
- force_reset  output  1  to the driver's force_reset.
- frame_start  output  1  one-cycle pulse when a frame begins streaming.
- frame_overrun  output  1  sticky: a frame took longer than FRAME_CYCLES.

Behaviour:
- Reset values: all outputs 0; state IDLE; front bank = bank 0; both banks cleared to 0; timer 0; pending 0.
- Frame store: 2 banks x NUM_LEDS x 24 bits.
  - wr_en writes {g,r,b} to back[wr_addr] at the clock edge.
  - wr_addr >= NUM_LEDS is ignored.
  - The front bank is read only.
- Colour serving:
  - On request_valid at edge T, {green,red,blue}_out = front[next_led_request] and color_valid = 1 from T+1.
  - Values are held until the next request_valid.
  - An out-of-range index returns 0,0,0 with color_valid = 1.
  - color_valid clears to 0 when force_reset asserts.
- Frame timer:
  - Free-running 0..FRAME_CYCLES-1 while not in IDLE.
  - It is reloaded to 0 on every frame start.
- State IDLE:
  - force_reset = 0.
  - If enable_in = 1, go to RESET next cycle, so the first frame always starts with a latch pulse.
- State RESET:
  - force_reset = 1 for exactly RESET_CYCLES cycles.
  - On entry: if commit_pending = 1, swap front and back and clear commit_pending.
  - Afterwards go to STREAM, pulse frame_start for 1 cycle, and set timer to 0.
- State STREAM:
  - Leave when a request_valid with index NUM_LEDS-1 has been served (last LED).
  - If enable_in = 0, go to IDLE.
  - Otherwise go to HOLD.
- State HOLD:
  - Wait until timer = FRAME_CYCLES-1, then go to RESET.
  - If the timer already reached FRAME_CYCLES-1 while in STREAM, set frame_overrun and go straight from STREAM to RESET with no HOLD cycles.
- Commit:
  - commit_in sets commit_pending the next cycle.
  - If commit_in lands in the same cycle as the swap (RESET entry), the swap consumes it and commit_pending stays 0.
- Write during the swap cycle: the write lands in the pre-swap back bank, which becomes the front bank. This is legal and documented; host logic avoids it by idling while force_reset = 1.
- Requests outside STREAM are still answered (same lookup rule) but do not advance state.
- frame_overrun: cleared only by rst_in.
- rst_in mid-frame: immediate return to reset values next cycle, including force_reset = 0 and banks cleared.

Test Plan:
- Reset, write LED0 = {g=0x3F,r=0x1F,b=0x00} and LED1 = {0x00,0x00,0x1F}, commit, enable -> force_reset high for 8000 cycles, then frame_start; request idx 0 gives 0x3F/0x1F/0x00 at T+1 with color_valid = 1; idx 1 gives 0x00/0x00/0x1F.
- Write LED0 = 0xAA/0xBB/0xCC mid-frame without commit -> all later requests still return the old front value; commit_pending = 0.
- Commit mid-frame -> commit_pending = 1 until the next RESET entry; the following frame returns the new values; commit_pending drops on RESET entry.
- FRAME_CYCLES = 100, last request at cycle 30 -> HOLD until timer 99; next force_reset rises exactly 100 cycles after the previous frame_start; frame_overrun = 0.
- FRAME_CYCLES = 100, last request at cycle 150 -> frame_overrun = 1 (sticky); RESET follows immediately with no HOLD.
- Deassert enable_in mid-STREAM -> frame completes, state goes to IDLE, force_reset stays 0; assert rst_in during RESET -> force_reset = 0 next cycle and all colours read 0.
